// File: rtl/traffic_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// traffic_sensor_conditioner
//
// Front end for the traffic light controller. Each of the two raw road-sensor
// inputs is synchronized into the clk domain, debounced, and given a minimum
// assertion time before it is presented to the controller as a clean
// car-present level. Per-lane 8-bit arrival counters are kept for status.
//
// Ports:
//   clk         in   1  system clock, all state updates on the rising edge
//   reset       in   1  asynchronous, active-low reset
//   sensor_raw  in   2  raw detectors (bit1 = lane 1, bit0 = lane 2), async
//   count_clr   in   1  synchronous clear of both arrival counters
//   l1l2        out  2  qualified car-present levels (bit1 = lane 1), registered
//   arrive      out  2  one-cycle pulse per lane when its l1l2 bit rises
//   cnt1        out  8  lane 1 arrival count (wraps 255 -> 0)
//   cnt2        out  8  lane 2 arrival count (wraps 255 -> 0)
//
// Parameters:
//   SYNC_STAGES      synchronizer flops per raw input (>= 2)
//   DEBOUNCE_CYCLES  consecutive identical samples to accept a change (>= 1)
//   HOLD_CYCLES      minimum cycles l1l2 stays high once asserted (>= 1)
// ---------------------------------------------------------------------------
module traffic_sensor_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sensor_raw,
  input  logic       count_clr,
  output logic [1:0] l1l2,
  output logic [1:0] arrive,
  output logic [7:0] cnt1,
  output logic [7:0] cnt2
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] H_ONE    = HW'(1);

  typedef enum logic [1:0] {
    ST_ABSENT   = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_PRESENT  = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  logic [1:0] w_lvl_nxt;
  logic [1:0] w_rise;

  logic [1:0] r_l1l2;
  logic [1:0] r_arrive;
  logic [7:0] r_cnt1;
  logic [7:0] r_cnt2;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DW-1:0]          r_dcnt;
    logic [DW-1:0]          w_dcnt_nxt;
    logic [DW-1:0]          w_dcnt_inc;
    logic [HW-1:0]          r_hcnt;
    logic [HW-1:0]          w_hcnt_nxt;
    logic [HW-1:0]          w_hcnt_inc;
    logic                   w_hold_done;
    logic                   w_lvl;
    logic                   w_arr;

    // ---- synchronizer chain: raw bit enters at [0], s leaves at the top ----
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], sensor_raw[g]};
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Saturating increments; the debounce counter also saturates so a long
    // low run in FALL_CHK waiting on the hold timer cannot wrap.
    assign w_dcnt_inc  = (r_dcnt == DEB_MAX)  ? r_dcnt : r_dcnt + D_ONE;
    assign w_hcnt_inc  = (r_hcnt == HOLD_MAX) ? r_hcnt : r_hcnt + H_ONE;
    // r_hcnt counts high cycles already completed including the current one,
    // so reaching HOLD_MAX means the output has been high long enough.
    assign w_hold_done = (r_hcnt == HOLD_MAX);

    // ---- FSM state register ----
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= ST_ABSENT;
        r_dcnt  <= '0;
        r_hcnt  <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_dcnt  <= w_dcnt_nxt;
        r_hcnt  <= w_hcnt_nxt;
      end
    end

    // ---- FSM next-state logic ----
    always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_hcnt_nxt  = r_hcnt;
      case (r_state)
        ST_ABSENT: begin
          if (w_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              w_state_nxt = ST_PRESENT;
              w_dcnt_nxt  = '0;
              w_hcnt_nxt  = H_ONE;
            end else begin
              w_state_nxt = ST_RISE_CHK;
              w_dcnt_nxt  = D_ONE;
            end
          end
        end
        ST_RISE_CHK: begin
          if (!w_s) begin
            w_state_nxt = ST_ABSENT;
            w_dcnt_nxt  = '0;
          end else if (w_dcnt_inc == DEB_MAX) begin
            w_state_nxt = ST_PRESENT;
            w_dcnt_nxt  = '0;
            w_hcnt_nxt  = H_ONE;
          end else begin
            w_dcnt_nxt  = w_dcnt_inc;
          end
        end
        ST_PRESENT: begin
          w_hcnt_nxt = w_hcnt_inc;
          if (!w_s) begin
            // With a one-sample debounce the first low sample already
            // qualifies, so release straight away if the hold has expired.
            if ((DEBOUNCE_CYCLES == 1) && w_hold_done) begin
              w_state_nxt = ST_ABSENT;
              w_dcnt_nxt  = '0;
              w_hcnt_nxt  = '0;
            end else begin
              w_state_nxt = ST_FALL_CHK;
              w_dcnt_nxt  = D_ONE;
            end
          end
        end
        ST_FALL_CHK: begin
          w_hcnt_nxt = w_hcnt_inc;
          if (w_s) begin
            w_state_nxt = ST_PRESENT;
            w_dcnt_nxt  = '0;
          end else if ((w_dcnt_inc == DEB_MAX) && w_hold_done) begin
            w_state_nxt = ST_ABSENT;
            w_dcnt_nxt  = '0;
            w_hcnt_nxt  = '0;
          end else begin
            w_dcnt_nxt  = w_dcnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_ABSENT;
          w_dcnt_nxt  = '0;
          w_hcnt_nxt  = '0;
        end
      endcase
    end

    // ---- FSM output decode: level from next state, pulse on 0 -> 1 ----
    always_comb begin
      w_lvl = (w_state_nxt == ST_PRESENT) || (w_state_nxt == ST_FALL_CHK);
      w_arr = w_lvl && !((r_state == ST_PRESENT) || (r_state == ST_FALL_CHK));
    end

    assign w_lvl_nxt[g] = w_lvl;
    assign w_rise[g]    = w_arr;
  end

  // ---- output registers and arrival counters ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_l1l2   <= 2'b00;
      r_arrive <= 2'b00;
      r_cnt1   <= 8'd0;
      r_cnt2   <= 8'd0;
    end else begin
      r_l1l2   <= w_lvl_nxt;
      r_arrive <= w_rise;
      // Clear wins over a same-edge arrival; the pulse itself is unaffected.
      if (count_clr) begin
        r_cnt1 <= 8'd0;
        r_cnt2 <= 8'd0;
      end else begin
        if (w_rise[1]) r_cnt1 <= r_cnt1 + 8'd1;
        if (w_rise[0]) r_cnt2 <= r_cnt2 + 8'd1;
      end
    end
  end

  assign l1l2   = r_l1l2;
  assign arrive = r_arrive;
  assign cnt1   = r_cnt1;
  assign cnt2   = r_cnt2;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_traffic_sensor_conditioner
//
// Drives directed and randomized sensor patterns and compares every cycle
// against a run-length based reference model: a lane rises once DEB
// consecutive synchronized ones are seen, and falls once DEB consecutive
// zeros are seen and at least HOLD cycles have elapsed since it rose.
// ---------------------------------------------------------------------------
module tb_traffic_sensor_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk;
  logic       reset;
  logic [1:0] sensor_raw;
  logic       count_clr;
  logic [1:0] l1l2;
  logic [1:0] arrive;
  logic [7:0] cnt1;
  logic [7:0] cnt2;

  traffic_sensor_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sensor_raw(sensor_raw),
    .count_clr (count_clr),
    .l1l2      (l1l2),
    .arrive    (arrive),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state (index 1 = lane 1, index 0 = lane 2)
  logic [1:0] m_pipe[$];
  int         m_ones[2];
  int         m_zeros[2];
  int         m_trise[2];
  int         m_cnt[2];
  logic [1:0] m_lvl;
  logic [1:0] m_rise;
  int         m_edge;

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(2'b00);
    for (int ln = 0; ln < 2; ln++) begin
      m_ones[ln]  = 0;
      m_zeros[ln] = 0;
      m_trise[ln] = 0;
      m_cnt[ln]   = 0;
    end
    m_lvl  = 2'b00;
    m_rise = 2'b00;
    m_edge = 0;
  endtask

  task automatic model_edge(input logic [1:0] raw, input logic clr);
    logic [1:0] s;
    s = m_pipe.pop_front();
    m_pipe.push_back(raw);
    m_edge++;
    for (int ln = 0; ln < 2; ln++) begin
      if (s[ln]) begin
        m_ones[ln]++;
        m_zeros[ln] = 0;
      end else begin
        m_zeros[ln]++;
        m_ones[ln] = 0;
      end
      m_rise[ln] = 1'b0;
      if (!m_lvl[ln] && m_ones[ln] >= DEB) begin
        m_lvl[ln]   = 1'b1;
        m_rise[ln]  = 1'b1;
        m_trise[ln] = m_edge;
      end else if (m_lvl[ln] && m_zeros[ln] >= DEB &&
                   (m_edge - m_trise[ln]) >= HOLD) begin
        m_lvl[ln] = 1'b0;
      end
      if (clr) m_cnt[ln] = 0;
      else if (m_rise[ln]) m_cnt[ln] = (m_cnt[ln] + 1) % 256;
    end
  endtask

  // one clock: apply inputs, advance model on the edge, compare on negedge
  task automatic step(input logic [1:0] raw, input logic clr);
    sensor_raw = raw;
    count_clr  = clr;
    @(posedge clk);
    if (reset) model_edge(raw, clr);
    else model_reset();
    @(negedge clk);
    check_val("l1l2",   32'(l1l2),   32'(m_lvl));
    check_val("arrive", 32'(arrive), 32'(m_rise));
    check_val("cnt1",   32'(cnt1),   32'(m_cnt[1]));
    check_val("cnt2",   32'(cnt2),   32'(m_cnt[0]));
  endtask

  initial begin
    int         hi;
    int         fall_at;
    logic [7:0] c0;
    logic [1:0] rv;
    int         len;

    reset      = 1'b0;
    sensor_raw = 2'b00;
    count_clr  = 1'b0;
    model_reset();
    @(negedge clk);

    // reset hold with both sensors active, then release and measure latency
    repeat (6) step(2'b11, 1'b0);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(2'b11, 1'b0);
      if (i == 5) check_val("rst_lat_pre", 32'(l1l2), 32'h0);
      if (i == 6) begin
        check_val("rst_lat_l1l2",   32'(l1l2),   32'h3);
        check_val("rst_lat_arrive", 32'(arrive), 32'h3);
        check_val("rst_lat_cnt1",   32'(cnt1),   32'h1);
        check_val("rst_lat_cnt2",   32'(cnt2),   32'h1);
      end
      if (i == 7) check_val("rst_pulse_end", 32'(arrive), 32'h0);
    end
    repeat (16) step(2'b00, 1'b0);

    // glitch rejection: 3 cycles high never qualifies
    c0 = cnt1;
    hi = 0;
    repeat (3) step(2'b10, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(2'b00, 1'b0);
      hi += int'(l1l2[1]);
    end
    check_val("glitch_lvl", 32'(hi),   32'h0);
    check_val("glitch_cnt", 32'(cnt1), 32'(c0));
    // 4 cycles high qualifies on the 6th edge
    for (int i = 1; i <= 6; i++) begin
      step((i <= 4) ? 2'b10 : 2'b00, 1'b0);
      if (i == 5) check_val("qual4_pre", 32'(l1l2[1]), 32'h0);
      if (i == 6) check_val("qual4_lvl", 32'(l1l2[1]), 32'h1);
    end
    repeat (16) step(2'b00, 1'b0);

    // minimum hold on lane 2
    hi = 0;
    for (int i = 1; i <= 30; i++) begin
      step((i <= 5) ? 2'b01 : 2'b00, 1'b0);
      hi += int'(l1l2[0]);
      if (i == 13) check_val("hold_last_hi", 32'(l1l2[0]), 32'h1);
      if (i == 14) check_val("hold_fall",    32'(l1l2[0]), 32'h0);
    end
    check_val("hold_total", 32'(hi), 32'd8);

    // bounce during release on lane 1 (hold long expired)
    repeat (16) step(2'b10, 1'b0);
    c0 = cnt1;
    step(2'b00, 1'b0);
    check_val("bounce_a", 32'(l1l2[1]), 32'h1);
    step(2'b00, 1'b0);
    check_val("bounce_b", 32'(l1l2[1]), 32'h1);
    step(2'b10, 1'b0);
    check_val("bounce_c", 32'(l1l2[1]), 32'h1);
    fall_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(2'b00, 1'b0);
      if (fall_at == 0 && !l1l2[1]) fall_at = i;
    end
    check_val("bounce_fall_at", 32'(fall_at), 32'd6);
    check_val("bounce_cnt",     32'(cnt1),    32'(c0));

    // randomized segments
    for (int seg = 0; seg < 60; seg++) begin
      rv  = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) step(rv, ($urandom_range(0, 15) == 0));
    end

    // counter wrap after 256 arrivals, then clear colliding with an arrival
    repeat (20) step(2'b00, 1'b0);
    step(2'b00, 1'b1);
    for (int a = 1; a <= 256; a++) begin
      repeat (6)  step(2'b10, 1'b0);
      repeat (10) step(2'b00, 1'b0);
      if (a == 255) check_val("wrap_255", 32'(cnt1), 32'd255);
    end
    check_val("wrap_0", 32'(cnt1), 32'd0);
    for (int i = 1; i <= 6; i++) step(2'b10, (i == 6));
    check_val("clr_prio_cnt",    32'(cnt1),      32'd0);
    check_val("clr_prio_arrive", 32'(arrive[1]), 32'h1);
    repeat (16) step(2'b00, 1'b0);

    // asynchronous reset between edges while lane 1 is present
    repeat (8) step(2'b10, 1'b0);
    check_val("areset_pre_lvl", 32'(l1l2), 32'h2);
    check_val("areset_pre_cnt", 32'(cnt1), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_val("areset_l1l2",   32'(l1l2),   32'h0);
    check_val("areset_cnt1",   32'(cnt1),   32'h0);
    check_val("areset_arrive", 32'(arrive), 32'h0);
    model_reset();
    repeat (3) step(2'b10, 1'b0);
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(2'b10, 1'b0);
      if (i == 6) check_val("areset_requal", 32'(cnt1), 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
- Upstream stage of the traffic light controller.
- Takes two raw, asynchronous road-sensor inputs: lane 1 and lane 2 car detectors.
- Synchronizes, debounces and enforces a minimum assertion time on each sensor, then drives the controller's 2-bit l1l2 input.
- Also keeps per-lane 8-bit arrival counters for status and debug.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per raw sensor input (minimum 2).
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples needed to accept a level change (minimum 1).
- HOLD_CYCLES, 8: minimum number of cycles a qualified sensor output stays high once asserted (minimum 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sensor_raw  input  2  raw detectors; bit1 = lane 1, bit0 = lane 2; asynchronous to clk.
- count_clr  input  1  synchronous clear of both arrival counters.
- l1l2  output  2  qualified car-present levels to the controller; bit1 = lane 1, bit0 = lane 2; registered.
- arrive  output  2  one-cycle pulse per lane on the cycle its l1l2 bit rises; registered.
- cnt1  output  8  lane 1 arrival count.
- cnt2  output  8  lane 2 arrival count.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - all synchronizer flops;
  - all FSMs to ABSENT;
  - debounce and hold counters to 0;
  - l1l2=2'b00, arrive=2'b00, cnt1=cnt2=8'd0.
- Outputs remain at reset values while reset=0.
- Reset asserted mid-operation aborts immediately: no pulse, no count.
- Each lane is independent and identical: synchronizer chain, then synchronized bit s, then per-lane FSM.
- FSM states: ABSENT, RISE_CHK, PRESENT, FALL_CHK. Lane output bit is 1 in PRESENT and FALL_CHK, 0 otherwise.
- ABSENT:
  - s=1 goes to RISE_CHK with dcnt=1.
  - If DEBOUNCE_CYCLES=1, go directly to PRESENT instead.
- RISE_CHK:
  - s=0 returns to ABSENT with dcnt=0.
  - s=1 increments dcnt. When dcnt reaches DEBOUNCE_CYCLES, go to PRESENT: l bit set, arrive bit pulses, lane counter increments, hcnt=1.
- PRESENT:
  - hcnt increments each cycle, saturating at HOLD_CYCLES.
  - s=0 goes to FALL_CHK with dcnt=1.
- FALL_CHK:
  - hcnt keeps incrementing (saturating).
  - s=1 returns to PRESENT with dcnt=0.
  - s=0 increments dcnt, saturating at DEBOUNCE_CYCLES.
  - Go to ABSENT (l bit cleared) only when dcnt has reached DEBOUNCE_CYCLES and hcnt has reached HOLD_CYCLES.
- Latency:
  - Raw 0→1 held stable reaches l1l2 after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges (6 at defaults).
  - Release latency is the same if the hold time has already expired; otherwise release occurs on the edge hcnt reaches HOLD_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronized samples never change l1l2 and never count.
- Counters wrap 255→0.
- count_clr=1 zeroes both counters on the next edge. count_clr has priority over a simultaneous arrival, so the counter becomes 0 (the arrive pulse still occurs).
- Both lanes qualifying on the same edge: both arrive bits pulse together and both counters increment.

Test Plan:
- Reset hold: reset=0 for 6 cycles with sensor_raw=2'b11 -> l1l2=00, arrive=00, cnt1=cnt2=0 throughout; after release, l1l2 becomes 11 exactly 6 edges later; arrive=11 for one cycle; cnt1=cnt2=1.
- Glitch rejection: sensor_raw bit1 high for 3 cycles, then low -> l1l2 stays 00, cnt1 stays 0; 4+ cycles high -> l1l2[1]=1 at edge 6 after the raw rise.
- Minimum hold: lane 2 raw high for 5 cycles (qualifies at edge 6), then low -> l1l2[0] stays high a total of 8 cycles before clearing, not earlier.
- Bounce during release: lane 1 in PRESENT, raw low 2 cycles, high 1, low steady -> l1l2[1] stays 1 through the bounce and falls after 4 consecutive low samples (hold expired); cnt1 unchanged.
- Counter wrap/clear: 256 qualified lane-1 arrivals -> cnt1=0; then one arrival with count_clr=1 on its qualifying edge -> cnt1=0, arrive[1] pulses.
- Async reset mid-operation: reset driven low between clock edges while l1l2=10 -> l1l2=00 and cnt1=0 immediately, before the next clk edge.
